// File: rtl/dmi_boot_sequencer.sv
// Preloads an SRAM image through the debug module's system-bus access registers,
// writes DPC with the boot address and resumes the hart, entirely over DMI.
module dmi_boot_sequencer #(
  parameter int unsigned PollMax  = 1024,
  parameter logic [2:0]  SbAccess = 3'd2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] boot_addr_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  input  logic [31:0] word_addr_i,
  input  logic [31:0] word_data_i,
  input  logic        word_new_sec_i,
  input  logic        word_last_i,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [6:0]  dmi_req_addr_o,
  output logic [1:0]  dmi_req_op_o,
  output logic [31:0] dmi_req_data_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [31:0] dmi_resp_data_i,
  input  logic [1:0]  dmi_resp_op_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned CntW = $clog2(PollMax + 1);

  localparam logic [6:0] AddrData0      = 7'h04;
  localparam logic [6:0] AddrDmControl  = 7'h10;
  localparam logic [6:0] AddrDmStatus   = 7'h11;
  localparam logic [6:0] AddrCommand    = 7'h17;
  localparam logic [6:0] AddrSbcs       = 7'h38;
  localparam logic [6:0] AddrSbAddress0 = 7'h39;
  localparam logic [6:0] AddrSbData0    = 7'h3C;

  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_POLL_SB, S_CFG, S_FETCH, S_SADDR, S_SDATA,
    S_BOOT, S_HALT, S_POLL_H, S_CLR1, S_CMD, S_RES, S_CLR2
  } state_e;

  state_e          state_q, state_d, ret_q, ret_d;
  logic            wait_q, wait_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     boot_q, boot_d, addr_q, addr_d, data_q, data_d;
  logic            new_sec_q, new_sec_d, last_q, last_d, first_q, first_d;
  logic            done_q, done_d, err_q, err_d;
  logic            is_dmi;
  logic            resp_ok;

  // Only sbbusy and anyhalted are ever inspected in a read response.
  logic unused_resp_bits;
  assign unused_resp_bits = ^{dmi_resp_data_i[31:22], dmi_resp_data_i[20:9],
                              dmi_resp_data_i[7:0]};

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise any path that misses an assignment infers a latch.
  always_comb begin
    is_dmi         = 1'b1;
    dmi_req_addr_o = '0;
    dmi_req_op_o   = '0;
    dmi_req_data_o = '0;
    case (state_q)
      S_ACT, S_CLR1, S_CLR2: begin
        dmi_req_addr_o = AddrDmControl; dmi_req_op_o = OpWrite; dmi_req_data_o = 32'h0000_0001;
      end
      S_POLL_SB: begin dmi_req_addr_o = AddrSbcs; dmi_req_op_o = OpRead; end
      S_CFG: begin
        dmi_req_addr_o = AddrSbcs; dmi_req_op_o = OpWrite;
        dmi_req_data_o = {12'b0, SbAccess, 1'b1, 16'b0};
      end
      S_SADDR: begin dmi_req_addr_o = AddrSbAddress0; dmi_req_op_o = OpWrite; dmi_req_data_o = addr_q; end
      S_SDATA: begin dmi_req_addr_o = AddrSbData0; dmi_req_op_o = OpWrite; dmi_req_data_o = data_q; end
      S_BOOT:  begin dmi_req_addr_o = AddrData0; dmi_req_op_o = OpWrite; dmi_req_data_o = boot_q; end
      S_HALT: begin
        dmi_req_addr_o = AddrDmControl; dmi_req_op_o = OpWrite; dmi_req_data_o = 32'h8000_0001;
      end
      S_POLL_H: begin dmi_req_addr_o = AddrDmStatus; dmi_req_op_o = OpRead; end
      S_CMD: begin dmi_req_addr_o = AddrCommand; dmi_req_op_o = OpWrite; dmi_req_data_o = 32'h0023_07B1; end
      S_RES: begin
        dmi_req_addr_o = AddrDmControl; dmi_req_op_o = OpWrite; dmi_req_data_o = 32'h4000_0001;
      end
      default: is_dmi = 1'b0;
    endcase
  end

  assign dmi_req_valid_o  = is_dmi && !wait_q;
  assign dmi_resp_ready_o = is_dmi && wait_q;
  assign resp_ok          = dmi_resp_ready_o && dmi_resp_valid_i && (dmi_resp_op_i == 2'd0);
  assign word_ready_o     = (state_q == S_SDATA) && resp_ok;
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = done_q;
  assign error_o          = err_q;

  always_comb begin
    state_d = state_q; ret_d = ret_q; wait_d = wait_q; cnt_d = cnt_q;
    boot_d = boot_q; addr_d = addr_q; data_d = data_q;
    new_sec_d = new_sec_q; last_d = last_q; first_d = first_q;
    done_d = done_q; err_d = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ACT; boot_d = boot_addr_i; first_d = 1'b1;
          wait_d = 1'b0; done_d = 1'b0; err_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (word_valid_i) begin
          addr_d = word_addr_i; data_d = word_data_i;
          new_sec_d = word_new_sec_i; last_d = word_last_i;
          state_d = (word_new_sec_i || first_q) ? S_SADDR : S_SDATA;
        end
      end
      default: begin
        if (!wait_q) begin
          if (dmi_req_ready_i) wait_d = 1'b1;
        end else if (dmi_resp_valid_i) begin
          wait_d = 1'b0;
          if (dmi_resp_op_i != 2'd0) begin
            err_d = 1'b1; state_d = S_IDLE;
          end else begin
            case (state_q)
              S_ACT:   begin state_d = S_POLL_SB; ret_d = S_CFG; cnt_d = '0; end
              S_CFG:   begin state_d = S_POLL_SB; ret_d = S_FETCH; cnt_d = '0; end
              S_SADDR: begin state_d = S_SDATA; first_d = 1'b0; end
              S_SDATA: begin
                state_d = S_POLL_SB; cnt_d = '0;
                ret_d   = last_q ? S_BOOT : S_FETCH;
              end
              S_POLL_SB: begin
                if (!dmi_resp_data_i[21]) state_d = ret_q;
                else if (cnt_q == CntW'(PollMax - 1)) begin err_d = 1'b1; state_d = S_IDLE; end
                else cnt_d = cnt_q + CntW'(1);
              end
              S_BOOT: state_d = S_HALT;
              S_HALT: begin state_d = S_POLL_H; cnt_d = '0; end
              S_POLL_H: begin
                if (dmi_resp_data_i[8]) state_d = S_CLR1;
                else if (cnt_q == CntW'(PollMax - 1)) begin err_d = 1'b1; state_d = S_IDLE; end
                else cnt_d = cnt_q + CntW'(1);
              end
              S_CLR1: state_d = S_CMD;
              S_CMD:  state_d = S_RES;
              S_RES:  state_d = S_CLR2;
              S_CLR2: begin state_d = S_IDLE; done_d = 1'b1; end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE; ret_q <= S_IDLE; wait_q <= 1'b0; cnt_q <= '0;
      boot_q <= '0; addr_q <= '0; data_q <= '0;
      new_sec_q <= 1'b0; last_q <= 1'b0; first_q <= 1'b0;
      done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; ret_q <= ret_d; wait_q <= wait_d; cnt_q <= cnt_d;
      boot_q <= boot_d; addr_q <= addr_d; data_q <= data_d;
      new_sec_q <= new_sec_d; last_q <= last_d; first_q <= first_d;
      done_q <= done_d; err_q <= err_d;
    end
  end

endmodule
